// File: rtl/alu_writeback_seq.sv
// ALU writeback sequencer: registers ALU results, owns the NZCV register and
// issues one (normal op) or two (long multiply, RdHi then RdLo) register-file writes.
module alu_writeback_seq #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  Result,
    input  logic [WIDTH-1:0]  Result2,
    input  logic [3:0]        ALUFlags,
    input  logic              is_long,
    input  logic              RegWrite,
    input  logic [1:0]        FlagWrite,
    input  logic              CondEx,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rd_lo,
    output logic [WIDTH-1:0]  ALUOut,
    output logic [3:0]        Flags,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [WIDTH-1:0]  wd3,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR1    = 2'd1,
        WR2    = 2'd2,
        RETIRE = 2'd3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   res2_q;
    logic [ADDR_W-1:0]  rd_q;
    logic [ADDR_W-1:0]  rd_lo_q;
    logic               is_long_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ALUOut    <= '0;
            res2_q    <= '0;
            rd_q      <= '0;
            rd_lo_q   <= '0;
            is_long_q <= 1'b0;
            Flags     <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ALUOut    <= Result;
                        res2_q    <= Result2;
                        rd_q      <= rd;
                        rd_lo_q   <= rd_lo;
                        is_long_q <= is_long;
                        // Flags follow FlagWrite/CondEx only; RegWrite never gates them.
                        if (FlagWrite[1] && CondEx) Flags[3:2] <= ALUFlags[3:2];
                        if (FlagWrite[0] && CondEx) Flags[1:0] <= ALUFlags[1:0];
                        state <= (RegWrite && CondEx) ? WR1 : RETIRE;
                    end
                end
                WR1:     state <= is_long_q ? WR2 : IDLE;
                WR2:     state <= IDLE;
                RETIRE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode of the write port from the state and the latched operands.
    always_comb begin
        in_ready = 1'b0;
        we3      = 1'b0;
        wa3      = '0;
        wd3      = '0;
        done     = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            WR1: begin
                we3  = 1'b1;
                wa3  = rd_q;
                wd3  = ALUOut;
                done = ~is_long_q;
            end
            WR2: begin
                we3  = 1'b1;
                wa3  = rd_lo_q;
                wd3  = res2_q;
                done = 1'b1;
            end
            RETIRE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule
